// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan driver.
// All patterns are active-low: a 0 bit lights the segment.
package seg7_pkg;

  localparam logic [7:0] BLANK_PATTERN = 8'hFF;
  localparam logic       ANODE_OFF     = 1'b1;

  // Bits 6..0 map to segments g..a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble + decimal point to active-low 8-bit segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  assign pattern = {~dp, hex_to_seg(nibble)};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-digit slot divider with anti-ghost
// blanking, frame-synchronous display updates and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    sysclk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic                    ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              bcd7
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]                div;
  logic [IDX_W-1:0]                idx;
  logic [NUM_DIGITS-1:0][3:0]      pending;
  logic [NUM_DIGITS-1:0]           pending_dp;
  logic                            pending_flag;
  logic [NUM_DIGITS-1:0][3:0]      shown;
  logic [NUM_DIGITS-1:0]           shown_dp;

  logic                            term_count;
  logic                            frame_edge;
  logic                            in_blank;
  logic                            dark;
  logic [NUM_DIGITS-1:0]           an_sel;
  logic [NUM_DIGITS-1:0]           lz_dark;
  logic                            all_zero_above;
  logic [7:0]                      pattern;

  assign term_count = (div == DIV_LAST);
  assign frame_edge = term_count && (idx == IDX_LAST);
  assign in_blank   = (div < BLANK_END);
  assign ready      = ~pending_flag;

  seg7_decoder u_decoder (
    .nibble  (shown[idx]),
    .dp      (shown_dp[idx]),
    .pattern (pattern)
  );

  // A digit is suppressed only while every nibble from it upward is zero;
  // a lit dp keeps that digit visible but does not stop suppression below it.
  always_comb begin
    lz_dark        = '0;
    all_zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      all_zero_above = all_zero_above & (shown[k] == 4'h0);
      lz_dark[k]     = blank_lz & all_zero_above & ~shown_dp[k];
    end
  end

  always_comb begin
    an_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_sel[k] = (idx != IDX_W'(k));
    end
  end

  assign dark = !enable || in_blank || lz_dark[idx];

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= term_count ? '0 : div + DIV_W'(1);
      if (term_count) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // A load on the frame edge lands in pending after the old value moves to
  // the display, so the flag stays set and the new value waits a full frame.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      pending_dp   <= '0;
      pending_flag <= 1'b0;
      shown        <= '0;
      shown_dp     <= '0;
    end else begin
      if (frame_edge && pending_flag) begin
        shown        <= pending;
        shown_dp     <= pending_dp;
        pending_flag <= 1'b0;
      end
      if (load) begin
        pending      <= value;
        pending_dp   <= dp;
        pending_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      an   <= {NUM_DIGITS{ANODE_OFF}};
      bcd7 <= BLANK_PATTERN;
    end else if (dark) begin
      an   <= {NUM_DIGITS{ANODE_OFF}};
      bcd7 <= BLANK_PATTERN;
    end else begin
      an   <= an_sel;
      bcd7 <= pattern;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2.
// pos counts clock edges since reset release; outputs after edge pos reflect slot state pos-1.
module tb_seg7_scan_driver;

  logic        sysclk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic        ready;
  logic [3:0]  an;
  logic [7:0]  bcd7;

  int total;
  int bad;
  int pos;

  localparam logic [3:0][7:0] D_ZERO = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
  localparam logic [3:0][7:0] D_12AF = {8'hF9, 8'hA4, 8'h88, 8'h8E};
  localparam logic [3:0][7:0] D_2222 = {8'hA4, 8'hA4, 8'hA4, 8'hA4};
  localparam logic [3:0][7:0] D_LZ   = {8'hFF, 8'h40, 8'hFF, 8'h92};
  localparam logic [3:0][7:0] D_0005 = {8'hC0, 8'h40, 8'hC0, 8'h92};
  localparam logic [3:0][7:0] D_3210 = {8'hB0, 8'hA4, 8'hF9, 8'hC0};

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .value    (value),
    .dp       (dp),
    .load     (load),
    .blank_lz (blank_lz),
    .enable   (enable),
    .ready    (ready),
    .an       (an),
    .bcd7     (bcd7)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
    pos++;
  endtask

  // Expected {an, bcd7} after edge p, given per-digit patterns (8'hFF = dark digit).
  function automatic logic [11:0] exp_out(int p, logic [3:0][7:0] digs);
    int s;
    int dv;
    int ix;
    logic [3:0] one;
    s   = p - 1;
    dv  = s % 8;
    ix  = (s / 8) % 4;
    one = 4'b0001;
    if (dv < 2 || digs[ix] == 8'hFF) return {4'hF, 8'hFF};
    return {~(one << ix), digs[ix]};
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp       = 4'h0;
    blank_lz = 1'b0;
    enable   = 1'b1;
    #1 reset = 1'b0;
    #2;
    total++;
    if ({an, bcd7, ready} !== {4'hF, 8'hFF, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_state got=%h want=%h", {an, bcd7, ready}, {4'hF, 8'hFF, 1'b1});
    end
    @(posedge sysclk);
    @(posedge sysclk);
    #3 reset = 1'b1;
    pos = 0;
  endtask

  task automatic test_scan();
    logic [11:0] e;
    for (int i = 0; i < 32; i++) begin
      step();
      e = exp_out(pos, D_ZERO);
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL scan pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
    end
  endtask

  task automatic test_load();
    logic [11:0] e;
    logic        r;
    while (pos < 42) step();
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL load_idle_ready got=%b want=1", ready);
    end
    value = 16'h12AF;
    dp    = 4'h0;
    load  = 1'b1;
    while (pos < 96) begin
      step();
      load = 1'b0;
      e = exp_out(pos, (pos <= 64) ? D_ZERO : D_12AF);
      r = (pos < 64) ? 1'b0 : 1'b1;
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL load_disp pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
      total++;
      if (ready !== r) begin
        bad++;
        $display("[TB] FAIL load_ready pos=%0d got=%b want=%b", pos, ready, r);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e;
    logic        r;
    logic        prev;
    int          rises;
    prev  = ready;
    rises = 0;
    while (pos < 160) begin
      if (pos == 99) begin value = 16'h1111; load = 1'b1; end
      if (pos == 105) begin value = 16'h2222; load = 1'b1; end
      step();
      load = 1'b0;
      if (ready === 1'b1 && prev === 1'b0) rises++;
      prev = ready;
      e = exp_out(pos, (pos <= 128) ? D_12AF : D_2222);
      r = (pos >= 100 && pos < 128) ? 1'b0 : 1'b1;
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL b2b_disp pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
      total++;
      if (ready !== r) begin
        bad++;
        $display("[TB] FAIL b2b_ready pos=%0d got=%b want=%b", pos, ready, r);
      end
    end
    total++;
    if (rises != 1) begin
      bad++;
      $display("[TB] FAIL b2b_ready_rises got=%0d want=1", rises);
    end
  endtask

  task automatic test_blank_lz();
    logic [11:0] e;
    blank_lz = 1'b1;
    while (pos < 224) begin
      if (pos == 162) begin value = 16'h0005; dp = 4'b0100; load = 1'b1; end
      step();
      load = 1'b0;
      e = exp_out(pos, (pos <= 192) ? D_2222 : D_LZ);
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL lz_on pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
    end
    blank_lz = 1'b0;
    while (pos < 256) begin
      step();
      e = exp_out(pos, D_0005);
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL lz_off pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
    end
  endtask

  task automatic test_enable();
    logic [11:0] e;
    logic        r;
    while (pos < 261) step();
    enable = 1'b0;
    while (pos < 281) begin
      if (pos == 264) begin value = 16'h3210; dp = 4'h0; load = 1'b1; end
      step();
      load = 1'b0;
      total++;
      if ({an, bcd7} !== {4'hF, 8'hFF}) begin
        bad++;
        $display("[TB] FAIL dis_dark pos=%0d got=%h want=fff", pos, {an, bcd7});
      end
      if (pos == 266) begin
        total++;
        if (ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL dis_ready pos=%0d got=%b want=0", pos, ready);
        end
      end
    end
    enable = 1'b1;
    while (pos < 320) begin
      step();
      e = exp_out(pos, (pos <= 288) ? D_0005 : D_3210);
      r = (pos < 288) ? 1'b0 : 1'b1;
      total++;
      if ({an, bcd7} !== e) begin
        bad++;
        $display("[TB] FAIL reen_disp pos=%0d got=%h want=%h", pos, {an, bcd7}, e);
      end
      total++;
      if (ready !== r) begin
        bad++;
        $display("[TB] FAIL reen_ready pos=%0d got=%b want=%b", pos, ready, r);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [11:0] e;
    while (pos < 325) begin
      if (pos == 322) begin value = 16'hFFFF; dp = 4'hF; load = 1'b1; end
      step();
      load = 1'b0;
    end
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_pre_ready got=%b want=0", ready);
    end
    reset = 1'b0;
    #2;
    total++;
    if ({an, bcd7, ready} !== {4'hF, 8'hFF, 1'b1}) begin
      bad++;
      $display("[TB] FAIL rst_async got=%h want=%h", {an, bcd7, ready}, {4'hF, 8'hFF, 1'b1});
    end
    @(posedge sysclk);
    @(posedge sysclk);
    #3 reset = 1'b1;
    pos = 0;
    while (pos < 64) begin
      step();
      e = exp_out(pos, D_ZERO);
      total++;
      if ({an, bcd7, ready} !== {e, 1'b1}) begin
        bad++;
        $display("[TB] FAIL rst_restart pos=%0d got=%h want=%h", pos, {an, bcd7, ready}, {e, 1'b1});
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pos   = 0;
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_blank_lz();
    test_enable();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 100000, sysclk cycles per digit slot (>= 2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 1000, anti-ghost blank cycles at start of each slot (< CLK_DIV).
REQ-004 SHALL have port sysclk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-007 SHALL have port dp  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-008 SHALL have port load  input  1  single-cycle strobe capturing value/dp into pending register.
REQ-009 SHALL have port blank_lz  input  1  mode: 1 = suppress leading zeros.
REQ-010 SHALL have port enable  input  1  0 = all digits dark, scan continues.
REQ-011 SHALL have port ready  output  1  1 = no pending update outstanding.
REQ-012 SHALL have port an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when driving.
REQ-013 SHALL have port bcd7  output  8  bit7 = dp, bits6..0 = segments g..a, all active-low.

Function
REQ-014 Divider SHALL count 0..CLK_DIV-1 and wrap; on terminal count digit index SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0 (frame boundary).
REQ-015 While divider < BLANK_CYCLES, an SHALL be all ones and bcd7 SHALL be 8'hFF.
REQ-016 Otherwise, with enable = 1, an SHALL drive only bit [index] low and bcd7 SHALL show the displayed nibble [index] and dp [index].
REQ-017 Segment map SHALL be standard hex 0-F (e.g. 0 -> 7'h40, 8 -> 7'h00, F -> 7'h0E on bits6..0); dp lit -> bit7 = 0.
REQ-018 load = 1 SHALL capture value/dp into the pending register on that edge and drive ready = 0 from the next cycle.
REQ-019 Pending SHALL transfer to the displayed register on the frame-boundary edge; ready SHALL return to 1 on that same edge (no tearing within a frame).
REQ-020 load while ready = 0 SHALL overwrite pending (last write wins); only the latest value is displayed.
REQ-021 load coincident with a frame-boundary edge SHALL go to pending and display at the next boundary; the old pending value transfers on this edge.
REQ-022 With blank_lz = 1, digits above the highest nonzero nibble SHALL be dark (an bit high) unless their dp is set; digit 0 SHALL always be shown.
REQ-023 enable = 0 SHALL force an all ones and bcd7 = 8'hFF from the next cycle; the divider, index and load handshake SHALL continue unaffected.
REQ-024 an and bcd7 SHALL be registered outputs (one-cycle latency from index/divider state).

Reset
REQ-025 reset low SHALL immediately force an = all ones, bcd7 = 8'hFF, ready = 1, divider = 0, index = 0, displayed and pending = 0, pending flag clear.
REQ-026 reset asserted mid-frame SHALL discard any pending update; scan restarts at digit 0 with a blank interval after release.

Structure
REQ-027 Shared package seg7_pkg SHALL hold the hex-to-segment table/function, the blank pattern 8'hFF and the anode-off constant.
REQ-028 A combinational sub-module seg7_decoder (nibble, dp -> 8-bit pattern) SHALL be instantiated once.
REQ-029 Divider width SHALL be $clog2(CLK_DIV) and index width $clog2(NUM_DIGITS) (minimum 1).

Verification (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset released, no load -> an cycles 1110,1101,1011,0111 every 8 clocks, bcd7 = 8'hC0 outside blank slots, 8'hFF in the first 2 cycles of each slot.
REQ-031 load value=16'h12AF mid-frame -> ready = 0 until next boundary, then digits 0..3 show F (8'h8E), A (8'h88), 2 (8'hA4), 1 (8'hF9).
REQ-032 Two loads (16'h1111 then 16'h2222) inside one frame -> only 2222 ever displayed; ready rises once.
REQ-033 blank_lz=1, value=16'h0005, dp=4'b0100 -> digit 3 dark, digit 2 shows "0." (8'h40), digit 1 dark, digit 0 shows 5 (8'h92).
REQ-034 enable=0 for 20 clocks -> an all ones, bcd7 = 8'hFF; on re-enable scan resumes at the index reached, not digit 0.
REQ-035 reset pulse low while ready = 0 -> outputs blank immediately, ready = 1, and display shows 0 after release.
